// File: rtl/muxnx1_seq.sv
// N-channel, W-bit multiplexer with a registered output. It has two modes:
// direct select, and an auto-scan that round-robins over a channel mask with a programmable dwell.
module muxnx1_seq #(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int SW = 2,
  parameter int DW = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            E,
  input  logic            M,
  input  logic [SW-1:0]   A,
  input  logic [N*W-1:0]  I,
  input  logic [N-1:0]    K,
  input  logic [DW-1:0]   D,
  output logic [W-1:0]    P,
  output logic [SW-1:0]   S,
  output logic            V,
  output logic            T
);

  localparam int NS = 1 << SW;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    p_q, p_d;
  logic [SW-1:0]   s_q, s_d;
  logic            v_q, v_d;
  logic            t_q, t_d;
  logic [DW-1:0]   c_q, c_d;

  logic [W-1:0]    ch_s [NS];
  logic [NS-1:0]   sel_ok_s;
  logic [NS-1:0]   kpad_s;
  logic [2*N-1:0]  dbl_s;
  logic [N-1:0]    rot_s;
  logic [SW-1:0]   low_s;
  logic [SW-1:0]   next_s;

  // Select codes past N-1 (N not a power of two) map to a zero, invalid channel.
  genvar g;
  generate
    for (g = 0; g < NS; g++) begin : g_ch
      if (g < N) begin : g_real
        assign ch_s[g]     = I[g*W +: W];
        assign sel_ok_s[g] = 1'b1;
      end else begin : g_pad
        assign ch_s[g]     = '0;
        assign sel_ok_s[g] = 1'b0;
      end
    end
  endgenerate

  assign kpad_s = NS'(K);
  assign dbl_s  = {K, K};
  assign rot_s  = N'(dbl_s >> s_q);

  // Lowest set bit of the mask: the scan entry point.
  always_comb begin
    low_s = '0;
    for (int j = N - 1; j >= 0; j--) begin
      low_s = K[j] ? SW'(j) : low_s;
    end
  end

  // Priority scan of the mask rotated to start just after S. Offset N wraps back onto S itself.
  always_comb begin
    logic [SW:0] sum;
    sum    = '0;
    next_s = s_q;
    for (int off = N; off >= 1; off--) begin
      sum    = {1'b0, s_q} + (SW+1)'(off);
      sum    = (sum >= (SW+1)'(N)) ? sum - (SW+1)'(N) : sum;
      next_s = rot_s[off % N] ? sum[SW-1:0] : next_s;
    end
  end

  // Next-state and next-output selection. P always follows the S being loaded.
  always_comb begin
    state_d = E ? (M ? ST_SCAN : ST_DIRECT) : ST_IDLE;
    s_d     = s_q;
    c_d     = c_q;
    v_d     = 1'b0;
    t_d     = 1'b0;
    case (state_d)
      ST_IDLE: begin
        s_d = s_q;
      end
      ST_DIRECT: begin
        c_d = D;
        if (sel_ok_s[A]) begin
          s_d = A;
          v_d = 1'b1;
        end else begin
          v_d = 1'b0;
        end
      end
      ST_SCAN: begin
        if (K == '0) begin
          c_d = D;
        end else if ((state_q != ST_SCAN) || !v_q) begin
          // Fresh entry, or resuming after an empty mask.
          s_d = low_s;
          c_d = D;
          v_d = 1'b1;
          t_d = 1'b1;
        end else if ((c_q == '0) || !kpad_s[s_q]) begin
          s_d = next_s;
          c_d = D;
          v_d = 1'b1;
          t_d = 1'b1;
        end else begin
          c_d = c_q - DW'(1);
          v_d = 1'b1;
        end
      end
      default: begin
        s_d = s_q;
      end
    endcase
    p_d = v_d ? ch_s[s_d] : '0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      s_q     <= '0;
      v_q     <= 1'b0;
      t_q     <= 1'b0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      s_q     <= s_d;
      v_q     <= v_d;
      t_q     <= t_d;
      c_q     <= c_d;
    end
  end

  assign P = p_q;
  assign S = s_q;
  assign V = v_q;
  assign T = t_q;

endmodule

// File: tb/tb_muxnx1_seq.sv
// Self-checking bench for muxnx1_seq. It runs directed scenarios plus randomized traffic
// against an integer-level behavioural model.
module tb_muxnx1_seq;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int DW = 4;

  logic            CLK = 1'b0;
  logic            RST, E, M;
  logic [SW-1:0]   A;
  logic [N*W-1:0]  I;
  logic [N-1:0]    K;
  logic [DW-1:0]   D;
  logic [W-1:0]    P;
  logic [SW-1:0]   S;
  logic            V, T;

  muxnx1_seq #(.W(W), .N(N), .SW(SW), .DW(DW)) dut (
    .CLK(CLK), .RST(RST), .E(E), .M(M), .A(A), .I(I), .K(K), .D(D),
    .P(P), .S(S), .V(V), .T(T)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // Model state: mode 0 idle, 1 direct, 2 scan.
  int         m_mode = 0;
  logic [7:0] m_p    = '0;
  int         m_s    = 0;
  logic       m_v    = 1'b0;
  logic       m_t    = 1'b0;
  int         m_c    = 0;

  function automatic logic [7:0] chan_of(int k);
    return I[k*W +: W];
  endfunction

  function automatic int lowest_set();
    for (int j = 0; j < N; j++) if (K[j]) return j;
    return 0;
  endfunction

  function automatic int next_set_after(int s);
    for (int off = 1; off <= N; off++) if (K[(s + off) % N]) return (s + off) % N;
    return s;
  endfunction

  task automatic model_edge();
    if (RST) begin
      m_mode = 0; m_p = '0; m_s = 0; m_v = 1'b0; m_t = 1'b0; m_c = 0;
    end else if (!E) begin
      m_mode = 0; m_p = '0; m_v = 1'b0; m_t = 1'b0;
    end else if (!M) begin
      m_mode = 1; m_c = int'(D); m_t = 1'b0;
      if (int'(A) < N) begin
        m_s = int'(A); m_v = 1'b1; m_p = chan_of(m_s);
      end else begin
        m_v = 1'b0; m_p = '0;
      end
    end else begin
      if (K == '0) begin
        m_v = 1'b0; m_t = 1'b0; m_c = int'(D);
      end else if (m_mode != 2 || !m_v) begin
        m_s = lowest_set(); m_c = int'(D); m_v = 1'b1; m_t = 1'b1;
      end else if (m_c == 0 || !K[m_s]) begin
        m_s = next_set_after(m_s); m_c = int'(D); m_v = 1'b1; m_t = 1'b1;
      end else begin
        m_c = m_c - 1; m_v = 1'b1; m_t = 1'b0;
      end
      m_p = m_v ? chan_of(m_s) : 8'h00;
      m_mode = 2;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    RST = 1'b1; E = 1'($urandom); M = 1'($urandom); A = SW'($urandom);
    I = $urandom; K = N'($urandom); D = DW'($urandom);
    tick();
    tick();
    checks++;
    if ({P, S, V, T} !== 12'h000) $display("FAIL reset cyc=%0d got P=%h S=%0d V=%b T=%b exp all zero", cyc, P, S, V, T);
    else passes++;
  endtask

  task automatic test_direct();
    RST = 1'b0; E = 1'b1; M = 1'b0; A = 2'd2; I = 32'h44332211;
    tick();
    checks++;
    if ({P, S, V, T} !== {8'h33, 2'd2, 1'b1, 1'b0})
      $display("FAIL direct_a2 cyc=%0d got P=%h S=%0d V=%b T=%b exp P=33 S=2 V=1 T=0", cyc, P, S, V, T);
    else passes++;
    A = 2'd3;
    tick();
    checks++;
    if (P !== 8'h44) $display("FAIL direct_a3 cyc=%0d got P=%h exp P=44", cyc, P);
    else passes++;
    for (int i = 0; i < 16; i++) begin
      A = SW'($urandom); I = $urandom;
      tick();
      checks++;
      if ({P, S, V, T} !== {m_p, m_s[1:0], m_v, m_t})
        $display("FAIL direct_rand cyc=%0d got P=%h S=%0d V=%b T=%b exp P=%h S=%0d V=%b T=%b", cyc, P, S, V, T, m_p, m_s, m_v, m_t);
      else passes++;
    end
  endtask

  task automatic test_disable();
    A = 2'd2; I = 32'h44332211;
    tick();
    E = 1'b0;
    tick();
    checks++;
    if ({P, S, V, T} !== {8'h00, 2'd2, 1'b0, 1'b0})
      $display("FAIL disable cyc=%0d got P=%h S=%0d V=%b T=%b exp P=00 S=2 V=0 T=0", cyc, P, S, V, T);
    else passes++;
    E = 1'b1;
    tick();
    checks++;
    if ({P, S, V} !== {8'h33, 2'd2, 1'b1}) $display("FAIL reenable cyc=%0d got P=%h S=%0d V=%b exp P=33 S=2 V=1", cyc, P, S, V);
    else passes++;
  endtask

  task automatic test_scan_basic();
    int         es [8] = '{0, 0, 1, 1, 3, 3, 0, 0};
    logic       et [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] ep;
    M = 1'b1; K = 4'b1011; D = 4'd1;
    for (int i = 0; i < 8; i++) begin
      I = $urandom;
      tick();
      ep = I[es[i]*W +: W];
      checks++;
      if ({P, S, V, T} !== {ep, es[i][1:0], 1'b1, et[i]})
        $display("FAIL scan_basic[%0d] cyc=%0d got P=%h S=%0d V=%b T=%b exp P=%h S=%0d V=1 T=%b", i, cyc, P, S, V, T, ep, es[i], et[i]);
      else passes++;
    end
  endtask

  task automatic test_scan_edges();
    D = 4'd0; K = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({S, V, T} !== {2'd2, 1'b1, 1'b1}) $display("FAIL scan_d0_single cyc=%0d got S=%0d V=%b T=%b exp S=2 V=1 T=1", cyc, S, V, T);
      else passes++;
    end
    K = 4'b0000;
    tick();
    checks++;
    if ({P, V, T} !== {8'h00, 1'b0, 1'b0}) $display("FAIL scan_k0 cyc=%0d got P=%h V=%b T=%b exp P=00 V=0 T=0", cyc, P, V, T);
    else passes++;
    K = 4'b0010;
    tick();
    checks++;
    if ({S, V, T} !== {2'd1, 1'b1, 1'b1}) $display("FAIL scan_resume cyc=%0d got S=%0d V=%b T=%b exp S=1 V=1 T=1", cyc, S, V, T);
    else passes++;
  endtask

  task automatic test_mid_dwell();
    E = 1'b0;
    tick();
    E = 1'b1; M = 1'b1; K = 4'b0110; D = 4'd5;
    tick();
    tick();
    tick();
    checks++;
    if ({S, T} !== {2'd1, 1'b0}) $display("FAIL mid_dwell_setup cyc=%0d got S=%0d T=%b exp S=1 T=0", cyc, S, T);
    else passes++;
    K = 4'b0100;
    tick();
    checks++;
    if ({S, V, T} !== {2'd2, 1'b1, 1'b1}) $display("FAIL mid_dwell_clear cyc=%0d got S=%0d V=%b T=%b exp S=2 V=1 T=1", cyc, S, V, T);
    else passes++;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if ({S, T} !== {2'd2, (i == 6)}) $display("FAIL mid_dwell_reload[%0d] cyc=%0d got S=%0d T=%b exp S=2 T=%b", i, cyc, S, T, (i == 6));
      else passes++;
    end
  endtask

  task automatic test_sreset_midscan();
    E = 1'b0;
    tick();
    E = 1'b1; M = 1'b1; K = 4'b1000; D = 4'd4;
    tick();
    tick();
    tick();
    RST = 1'b1;
    #1;
    checks++;
    if ({P, S, V, T} !== {I[31:24], 2'd3, 1'b1, 1'b0})
      $display("FAIL sreset_before_edge cyc=%0d got P=%h S=%0d V=%b T=%b exp P=%h S=3 V=1 T=0", cyc, P, S, V, T, I[31:24]);
    else passes++;
    tick();
    checks++;
    if ({P, S, V, T} !== 12'h000) $display("FAIL sreset_edge cyc=%0d got P=%h S=%0d V=%b T=%b exp all zero", cyc, P, S, V, T);
    else passes++;
    RST = 1'b0; K = 4'b1010;
    tick();
    checks++;
    if ({S, V, T} !== {2'd1, 1'b1, 1'b1}) $display("FAIL sreset_restart cyc=%0d got S=%0d V=%b T=%b exp S=1 V=1 T=1", cyc, S, V, T);
    else passes++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      RST = ($urandom_range(0, 59) == 0);
      E   = ($urandom_range(0, 9) != 0);
      M   = ($urandom_range(0, 3) != 0);
      A   = SW'($urandom);
      I   = $urandom;
      if ($urandom_range(0, 7) == 0) K = ($urandom_range(0, 3) == 0) ? 4'b0000 : N'($urandom);
      if ($urandom_range(0, 5) == 0) D = DW'($urandom_range(0, 3));
      tick();
      checks++;
      if ({P, S, V, T} !== {m_p, m_s[1:0], m_v, m_t})
        $display("FAIL random cyc=%0d got P=%h S=%0d V=%b T=%b exp P=%h S=%0d V=%b T=%b", cyc, P, S, V, T, m_p, m_s, m_v, m_t);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_disable();
    test_scan_basic();
    test_scan_edges();
    test_mid_dwell();
    test_sreset_midscan();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
